hazard_scoreboard: RTL and testbench

//  Parametrised successor hazard unit for the 5-stage core. Generalises forwarding to NUM_FWD

---
 rtl/hazard_scoreboard.sv | 177 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding select, data-hazard stall, multi-cycle
// scoreboard with an in-flight op counter and post-completion hold.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rs*_d, rd_d, ...  decode-stage operand and destination info
//   rs*_e, rd_e, ...  execute-stage operand info, load flag
//   fwd_rd, fwd_we    packed destination and write-enable per source
//   mc_issue*, mc_done*  multi-cycle issue and writeback events
//   branch_taken      redirect from EX
//   mem_ready_m       D-cache ready
//   stall, flush      hazard stall and redirect flush
//   mc_stall          hold for multi-cycle completion
//   cache_stall       hold for the D-cache
//   fwd_rs1/fwd_rs2   0 = regfile, k = source k-1
//   sb_pending        pending-write bits (bit 0 always 0)
//   mc_count          in-flight multi-cycle ops
//
// Optional: define HAZARD_PERF_EN to add perf_stall_cyc and
// perf_flush_cnt counters.
module hazard_scoreboard #(
    parameter int NUM_FWD     = 3,
    parameter int MAX_OUT     = 2,
    parameter int HOLD_CYCLES = 1,
    localparam int SELW = $clog2(NUM_FWD + 1),
    localparam int CW   = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic                 rs1_used_d,
    input  logic                 rs2_used_d,
    input  logic [4:0]           rd_d,
    input  logic                 rd_used_d,
    input  logic                 mc_op_d,
    input  logic [4:0]           rs1_e,
    input  logic [4:0]           rs2_e,
    input  logic                 rs1_used_e,
    input  logic                 rs2_used_e,
    input  logic [4:0]           rd_e,
    input  logic                 load_e,
    input  logic [5*NUM_FWD-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]   fwd_we,
    input  logic                 mc_issue,
    input  logic [4:0]           mc_issue_rd,
    input  logic                 mc_done,
    input  logic [4:0]           mc_done_rd,
    input  logic                 branch_taken,
    input  logic                 mem_ready_m,
    output logic                 stall,
    output logic                 flush,
    output logic                 mc_stall,
    output logic                 cache_stall,
    output logic [SELW-1:0]      fwd_rs1,
    output logic [SELW-1:0]      fwd_rs2,
    output logic [31:0]          sb_pending,
    output logic [CW-1:0]        mc_count
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          perf_stall_cyc,
    output logic [31:0]          perf_flush_cnt
`endif
);

    localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUT);
    localparam logic [3:0]    HOLD_C = 4'(HOLD_CYCLES);

    logic [31:0]   sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hold_q, hold_d;

    logic load_use, sb_raw, sb_waw, cap_full;
    logic busy_e, acc_issue, dec_ok, sb_set;

    // Forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_rs1 = '0;
        fwd_rs2 = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we[k] && fwd_rd[k*5 +: 5] == rs1_e)
                fwd_rs1 = SELW'(k + 1);
            if (fwd_we[k] && fwd_rd[k*5 +: 5] == rs2_e)
                fwd_rs2 = SELW'(k + 1);
        end
        if (!rs1_used_e || rs1_e == 5'd0)
            fwd_rs1 = '0;
        if (!rs2_used_e || rs2_e == 5'd0)
            fwd_rs2 = '0;
    end

    assign load_use = load_e && rd_e != 5'd0 &&
                      ((rs1_used_d && rd_e == rs1_d) ||
                       (rs2_used_d && rd_e == rs2_d));
    assign sb_raw   = (rs1_used_d && sb_q[rs1_d]) ||
                      (rs2_used_d && sb_q[rs2_d]);
    assign sb_waw   = rd_used_d && sb_q[rd_d];
    assign cap_full = mc_op_d && cnt_q == MAX_C;

    assign flush       = branch_taken;
    // Instruction in ID is dead on a redirect; no point stalling it.
    assign stall       = (load_use || sb_raw || sb_waw || cap_full) &&
                         !flush;
    assign cache_stall = !mem_ready_m;

    assign busy_e   = (rs1_used_e && sb_q[rs1_e]) ||
                      (rs2_used_e && sb_q[rs2_e]);
    assign mc_stall = (cnt_q != '0 && busy_e) || hold_q != 4'd0;

    assign acc_issue = mc_issue && !flush;
    assign sb_set    = acc_issue && mc_issue_rd != 5'd0;
    // x0 issues are counted but never tracked, so a done on x0
    // must still retire one of them.
    assign dec_ok    = mc_done &&
                       (sb_q[mc_done_rd] || mc_done_rd == 5'd0);

    always_comb begin
        sb_d = sb_q;
        if (mc_done)
            sb_d[mc_done_rd] = 1'b0;
        // Set after clear: a new issue owns the register.
        if (sb_set)
            sb_d[mc_issue_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (acc_issue && !dec_ok && cnt_q != MAX_C)
            cnt_d = cnt_q + 1'b1;
        else if (!acc_issue && dec_ok && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        hold_d = hold_q;
        if (mc_done)
            hold_d = HOLD_C;
        else if (hold_q != 4'd0)
            hold_d = hold_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_q   <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            sb_q   <= sb_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign sb_pending = sb_q;
    assign mc_count   = cnt_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] pstall_q, pflush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pstall_q <= '0;
            pflush_q <= '0;
        end else begin
            if (stall || mc_stall || cache_stall)
                pstall_q <= pstall_q + 32'd1;
            if (flush)
                pflush_q <= pflush_q + 32'd1;
        end
    end

    assign perf_stall_cyc = pstall_q;
    assign perf_flush_cnt = pflush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of hazard_scoreboard
// with default parameters (NUM_FWD=3, MAX_OUT=2, HOLD_CYCLES=1).
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        rs1_used_d, rs2_used_d, rd_used_d, mc_op_d;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        rs1_used_e, rs2_used_e, load_e;
    logic [14:0] fwd_rd;
    logic [2:0]  fwd_we;
    logic        mc_issue, mc_done;
    logic [4:0]  mc_issue_rd, mc_done_rd;
    logic        branch_taken, mem_ready_m;
    logic        stall, flush, mc_stall, cache_stall;
    logic [1:0]  fwd_rs1, fwd_rs2;
    logic [31:0] sb_pending;
    logic [1:0]  mc_count;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .rd_d(rd_d), .rd_used_d(rd_used_d), .mc_op_d(mc_op_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rs1_used_e(rs1_used_e), .rs2_used_e(rs2_used_e),
        .rd_e(rd_e), .load_e(load_e),
        .fwd_rd(fwd_rd), .fwd_we(fwd_we),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_done(mc_done), .mc_done_rd(mc_done_rd),
        .branch_taken(branch_taken), .mem_ready_m(mem_ready_m),
        .stall(stall), .flush(flush), .mc_stall(mc_stall),
        .cache_stall(cache_stall),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .sb_pending(sb_pending), .mc_count(mc_count)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t exq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        exq.push_back(e);
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exq.size() == 0) begin
            errors++;
            $error("FAIL queue_empty observed=%0h", obs);
        end else begin
            e = exq.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h",
                       e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rs1_d = 0; rs2_d = 0; rd_d = 0;
        rs1_used_d = 0; rs2_used_d = 0; rd_used_d = 0;
        mc_op_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0;
        rs1_used_e = 0; rs2_used_e = 0; load_e = 0;
        fwd_rd = '0; fwd_we = '0;
        mc_issue = 0; mc_issue_rd = 0;
        mc_done = 0; mc_done_rd = 0;
        branch_taken = 0; mem_ready_m = 1;
    endtask

    initial begin
        quiet();
        rst_n = 0;
        cyc();
        cyc();
        // reset state
        push("rst_sb", 0);       push("rst_cnt", 0);
        push("rst_stall", 0);    push("rst_mcst", 0);
        push("rst_flush", 0);    push("rst_cst", 0);
        push("rst_fwd1", 0);
        pop(sb_pending); pop(mc_count);
        pop(stall); pop(mc_stall);
        pop(flush); pop(cache_stall);
        pop(fwd_rs1);
        rst_n = 1;
        cyc();

        // forwarding: youngest match wins
        fwd_we = 3'b011;
        fwd_rd = {5'd0, 5'd5, 5'd5};
        rs1_e = 5; rs1_used_e = 1;
        rs2_e = 5; rs2_used_e = 0;
        push("fwd_young", 1); push("fwd_unused", 0);
        #1; pop(fwd_rs1); pop(fwd_rs2);
        fwd_we = 3'b110;
        fwd_rd = {5'd5, 5'd5, 5'd3};
        push("fwd_mid", 2);
        #1; pop(fwd_rs1);
        fwd_we = 3'b100;
        rs2_used_e = 1;
        push("fwd_old", 3); push("fwd_old2", 3);
        #1; pop(fwd_rs1); pop(fwd_rs2);
        rs1_e = 0;
        fwd_rd = {5'd0, 5'd0, 5'd0};
        fwd_we = 3'b111;
        push("fwd_x0", 0);
        #1; pop(fwd_rs1);
        quiet();

        // load-use
        load_e = 1; rd_e = 7; rs2_d = 7; rs2_used_d = 1;
        push("lu_stall", 1);
        #1; pop(stall);
        rs2_used_d = 0;
        push("lu_unused", 0);
        #1; pop(stall);
        rs2_used_d = 1; branch_taken = 1;
        push("lu_flushmask", 0); push("flush", 1);
        #1; pop(stall); pop(flush);
        quiet();
        mem_ready_m = 0;
        push("cache_stall", 1);
        #1; pop(cache_stall);
        quiet();

        // scoreboard RAW/WAW and completion
        mc_issue = 1; mc_issue_rd = 9;
        cyc();
        quiet();
        push("iss_sb", 32'h200); push("iss_cnt", 1);
        pop(sb_pending); pop(mc_count);
        rs1_d = 9; rs1_used_d = 1;
        push("raw_stall", 1);
        #1; pop(stall);
        rs1_used_d = 0; rd_d = 9; rd_used_d = 1;
        push("waw_stall", 1);
        #1; pop(stall);
        rd_used_d = 0; rs2_e = 9; rs2_used_e = 1;
        push("mc_busy", 1);
        #1; pop(mc_stall);
        rs2_used_e = 0; rs1_used_d = 1;
        mc_done = 1; mc_done_rd = 9;
        push("raw_hold", 1);
        #1; pop(stall);
        cyc();
        mc_done = 0;
        push("done_sb", 0); push("done_cnt", 0);
        push("raw_clear", 0); push("hold_on", 1);
        #1;
        pop(sb_pending); pop(mc_count); pop(stall); pop(mc_stall);
        cyc();
        push("hold_off", 0);
        pop(mc_stall);
        quiet();

        // same-cycle set and clear
        mc_issue = 1; mc_issue_rd = 9;
        cyc();
        mc_done = 1; mc_done_rd = 9;
        cyc();
        quiet();
        push("sc_sb", 32'h200); push("sc_cnt", 1);
        pop(sb_pending); pop(mc_count);
        mc_done = 1; mc_done_rd = 9;
        cyc();
        quiet();
        push("sc_done_cnt", 0);
        pop(mc_count);

        // capacity
        mc_issue = 1; mc_issue_rd = 3;
        cyc();
        mc_issue_rd = 0;
        cyc();
        quiet();
        push("cap_cnt", 2); push("cap_sb", 32'h8);
        pop(mc_count); pop(sb_pending);
        mc_op_d = 1;
        push("cap_stall", 1);
        #1; pop(stall);
        mc_done = 1; mc_done_rd = 3;
        cyc();
        mc_done = 0;
        push("cap_cnt1", 1); push("cap_release", 0);
        #1; pop(mc_count); pop(stall);
        quiet();
        mc_done = 1; mc_done_rd = 12;
        cyc();
        quiet();
        push("done_nonpend_cnt", 1); push("done_nonpend_sb", 0);
        pop(mc_count); pop(sb_pending);

        // reset mid-operation
        mc_issue = 1; mc_issue_rd = 6;
        cyc();
        quiet();
        push("mid_sb", 32'h40); push("mid_cnt", 2);
        pop(sb_pending); pop(mc_count);
        rst_n = 0;
        cyc();
        push("rst2_sb", 0); push("rst2_cnt", 0);
        push("rst2_mcst", 0);
        pop(sb_pending); pop(mc_count); pop(mc_stall);
        rst_n = 1;
        cyc();

        // issue killed by flush
        mc_issue = 1; mc_issue_rd = 10; branch_taken = 1;
        push("fl_flush", 1);
        #1; pop(flush);
        cyc();
        quiet();
        push("fl_sb", 0); push("fl_cnt", 0);
        pop(sb_pending); pop(mc_count);

        if (exq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expect count=%0d required=0",
                     exq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
